// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the two-port single-port-SRAM arbiter.
//   - Width constants of the SRAM wrapper interface (address, data, byte
//     enables).
//   - Power-down FSM state encoding (ACTIVE / PD / WAKE).
//   - Packed per-port command bundle, so the top can mux ports generically.
//   - is_read(): an access with no byte enables set is a read.
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int ADR_W   = 11;
  localparam int DAT_W   = 32;
  localparam int BE_W    = 4;
  localparam int N_PORTS = 2;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    PD     = 2'd1,
    WAKE   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [BE_W-1:0]  we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] wdata;
  } arb_cmd_t;

  function automatic logic is_read(input logic [BE_W-1:0] we);
    return (we == '0);
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// ---------------------------------------------------------------------------
// sram_arb_rr
//   Two-way request picker with a last-grant register.
//   FIXED_PRIO=1 : port 0 wins every tie.
//   FIXED_PRIO=0 : round-robin, the port not granted most recently wins a
//                  tie. last_reg resets to 1 so port 0 wins the first tie.
//   Ports:
//     CLK      clock
//     reset_n  synchronous active-low reset
//     enable   grants may be issued this cycle
//     req      per-port request
//     gnt      one-hot (or zero) grant, combinational from req and last_reg
// ---------------------------------------------------------------------------
module sram_arb_rr
  import sram_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [N_PORTS-1:0] req,
  output logic [N_PORTS-1:0] gnt
);

  // Index of the port granted most recently.
  logic last_reg;
  logic last_next;

  always_comb begin
    gnt = '0;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Tie: port 0 wins under fixed priority, or when port 1 went last.
        2'b11:   gnt = (FIXED_PRIO || last_reg) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    last_next = last_reg;
    if (gnt[0]) begin
      last_next = 1'b0;
    end else if (gnt[1]) begin
      last_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end

endmodule

// File: rtl/sram_sp_arbiter.sv
// ---------------------------------------------------------------------------
// sram_sp_arbiter
//   Shares one single-port SRAM between two requesters and powers the SRAM
//   down after IDLE_LIMIT consecutive idle cycles.
//   Parameters:
//     IDLE_LIMIT  idle cycles before power-down (default 16)
//     FIXED_PRIO  1: port 0 always wins, 0: round-robin
//   Ports:
//     CLK, reset_n                 clock, synchronous active-low reset
//     scan_mode                    holds the SRAM out of power-down
//     pN_req/we/adr/wdata          requester N command (held until pN_gnt)
//     pN_gnt                       command accepted this cycle
//     pN_rvalid/pN_rdata           read return, one cycle after the grant
//     mem_me/we/adr/d, mem_q       SRAM wrapper access port
//     mem_pd                       SRAM power-down request
//   A grant costs no latency in ACTIVE; waking from PD takes one WAKE cycle,
//   so a request issued in PD is granted two cycles later.
// ---------------------------------------------------------------------------
module sram_sp_arbiter
  import sram_arb_pkg::*;
#(
  parameter int IDLE_LIMIT = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             scan_mode,
  input  logic             p0_req,
  input  logic [BE_W-1:0]  p0_we,
  input  logic [ADR_W-1:0] p0_adr,
  input  logic [DAT_W-1:0] p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [DAT_W-1:0] p0_rdata,
  input  logic             p1_req,
  input  logic [BE_W-1:0]  p1_we,
  input  logic [ADR_W-1:0] p1_adr,
  input  logic [DAT_W-1:0] p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [DAT_W-1:0] p1_rdata,
  output logic             mem_me,
  output logic [BE_W-1:0]  mem_we,
  output logic [ADR_W-1:0] mem_adr,
  output logic [DAT_W-1:0] mem_d,
  input  logic [DAT_W-1:0] mem_q,
  output logic             mem_pd
);

  localparam int               CNT_W    = (IDLE_LIMIT < 1) ? 1 : $clog2(IDLE_LIMIT + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_LIMIT);

  // Per-port views so the datapath can be written once for both ports.
  logic     [N_PORTS-1:0]            req;
  arb_cmd_t [N_PORTS-1:0]            cmd;
  logic     [N_PORTS-1:0]            gnt;
  logic     [N_PORTS-1:0][DAT_W-1:0] rdata;

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [N_PORTS-1:0] rvalid_reg, rvalid_next;
  logic             grant_en;

  assign req    = {p1_req, p0_req};
  assign cmd[0] = '{we: p0_we, adr: p0_adr, wdata: p0_wdata};
  assign cmd[1] = '{we: p1_we, adr: p1_adr, wdata: p1_wdata};

  // Grants only in ACTIVE, and never while reset is held, so a read that
  // would be granted in the reset cycle produces no access and no rvalid.
  assign grant_en = reset_n && (state_reg == ACTIVE);

  sram_arb_rr #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_rr (
    .CLK     (CLK),
    .reset_n (reset_n),
    .enable  (grant_en),
    .req     (req),
    .gnt     (gnt)
  );

  // -------------------------------------------------------------------------
  // Per-port read return path
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign rvalid_next[gi] = gnt[gi] && is_read(cmd[gi].we);
      // The SRAM's Q is shared, so each port sees it only on its own rvalid.
      assign rdata[gi]       = rvalid_reg[gi] ? mem_q : '0;
    end
  endgenerate

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid_reg[0];
  assign p1_rvalid = rvalid_reg[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];

  // -------------------------------------------------------------------------
  // SRAM access mux
  // -------------------------------------------------------------------------
  always_comb begin
    mem_me  = 1'b0;
    mem_we  = '0;
    // Address/data default to port 0 to keep the mux shallow; they are
    // don't-care whenever mem_me is low.
    mem_adr = cmd[0].adr;
    mem_d   = cmd[0].wdata;
    if (gnt[1]) begin
      mem_me  = 1'b1;
      mem_we  = cmd[1].we;
      mem_adr = cmd[1].adr;
      mem_d   = cmd[1].wdata;
    end else if (gnt[0]) begin
      mem_me  = 1'b1;
      mem_we  = cmd[0].we;
    end
  end

  // Scan mode and reset both keep the macro powered.
  assign mem_pd = reset_n && (state_reg == PD) && !scan_mode;

  // -------------------------------------------------------------------------
  // Power-down FSM and idle counter
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = idle_cnt_reg;
    case (state_reg)
      ACTIVE: begin
        // A cycle is idle only if nothing is requested and no read data is
        // still being returned.
        if ((req == '0) && (rvalid_reg == '0)) begin
          if (idle_cnt_reg != IDLE_MAX) begin
            idle_cnt_next = idle_cnt_reg + CNT_W'(1);
          end
        end else begin
          idle_cnt_next = '0;
        end
        // A request arriving as the counter saturates is served instead.
        if ((req == '0) && (idle_cnt_reg == IDLE_MAX) && !scan_mode) begin
          state_next = PD;
        end
      end
      PD: begin
        if ((req != '0) || scan_mode) begin
          state_next = WAKE;
        end
      end
      WAKE: begin
        state_next    = ACTIVE;
        idle_cnt_next = '0;
      end
      default: begin
        state_next    = ACTIVE;
        idle_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_reg    <= ACTIVE;
      idle_cnt_reg <= '0;
      rvalid_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      rvalid_reg   <= rvalid_next;
    end
  end

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_sp_arbiter
//   Two arbiters side by side: instance 0 round-robin, instance 1 fixed
//   priority, each with its own behavioural SRAM. A cycle-level reference
//   model (shadow memory, sleep flags, idle count, last winner) predicts
//   every output each cycle. Directed scenarios run first, then random.
// ---------------------------------------------------------------------------
module tb_sram_sp_arbiter;

  localparam int IDLE_LIMIT = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic reset_n;
  logic scan_mode;

  // Port signals, index = inst*2 + port
  logic [3:0]        req;
  logic [3:0][3:0]   we;
  logic [3:0][10:0]  adr;
  logic [3:0][31:0]  wdata;
  wire  [3:0]        gnt;
  wire  [3:0]        rvalid;
  wire  [3:0][31:0]  rdata;
  // SRAM side, index = inst
  wire  [1:0]        me;
  wire  [1:0]        pd;
  wire  [1:0][3:0]   mwe;
  wire  [1:0][10:0]  madr;
  wire  [1:0][31:0]  md;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [31:0] mem [2048] = '{default: 32'h0};
      logic [31:0] q_r;

      always @(posedge CLK) begin
        if (me[gi]) begin
          if (mwe[gi] == 4'h0) begin
            q_r <= mem[madr[gi]];
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (mwe[gi][b]) mem[madr[gi]][8*b +: 8] <= md[gi][8*b +: 8];
            end
          end
        end
      end

      sram_sp_arbiter #(
        .IDLE_LIMIT (IDLE_LIMIT),
        .FIXED_PRIO (gi)
      ) u_dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .scan_mode (scan_mode),
        .p0_req    (req[2*gi]),
        .p0_we     (we[2*gi]),
        .p0_adr    (adr[2*gi]),
        .p0_wdata  (wdata[2*gi]),
        .p0_gnt    (gnt[2*gi]),
        .p0_rvalid (rvalid[2*gi]),
        .p0_rdata  (rdata[2*gi]),
        .p1_req    (req[2*gi+1]),
        .p1_we     (we[2*gi+1]),
        .p1_adr    (adr[2*gi+1]),
        .p1_wdata  (wdata[2*gi+1]),
        .p1_gnt    (gnt[2*gi+1]),
        .p1_rvalid (rvalid[2*gi+1]),
        .p1_rdata  (rdata[2*gi+1]),
        .mem_me    (me[gi]),
        .mem_we    (mwe[gi]),
        .mem_adr   (madr[gi]),
        .mem_d     (md[gi]),
        .mem_q     (q_r),
        .mem_pd    (pd[gi])
      );
    end
  endgenerate

  // Reference model state, per instance
  bit          m_asleep  [2];
  bit          m_waking  [2];
  int          m_idle    [2];
  int          m_last    [2];
  int          m_pend    [2];
  logic [31:0] m_pend_data [2];
  logic [31:0] shadow [2][2048];
  int          win [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc=%0d got=%h exp=%h", tag, k, cycle, got, exp);
    end
  endtask

  // Let combinational outputs settle, predict this cycle and compare.
  task automatic settle_check();
    int w;
    int i;
    #2;
    for (int k = 0; k < 2; k++) begin
      w = -1;
      if (reset_n && !m_asleep[k] && !m_waking[k]) begin
        if (req[2*k] && req[2*k+1]) w = (k == 1) ? 0 : ((m_last[k] == 1) ? 0 : 1);
        else if (req[2*k])          w = 0;
        else if (req[2*k+1])        w = 1;
      end
      win[k] = w;
      for (int p = 0; p < 2; p++) begin
        i = 2*k + p;
        chk("gnt",    k, 32'(gnt[i]),    32'(w == p));
        chk("rvalid", k, 32'(rvalid[i]), 32'(m_pend[k] == p));
        chk("rdata",  k, rdata[i],       (m_pend[k] == p) ? m_pend_data[k] : 32'h0);
      end
      chk("mem_pd", k, 32'(pd[k]),  32'(reset_n && m_asleep[k] && !scan_mode));
      chk("mem_me", k, 32'(me[k]),  32'(w >= 0));
      chk("mem_we", k, 32'(mwe[k]), (w >= 0) ? 32'(we[2*k+w]) : 32'h0);
      if (w >= 0) begin
        chk("mem_adr", k, 32'(madr[k]), 32'(adr[2*k+w]));
        chk("mem_d",   k, md[k],        wdata[2*k+w]);
      end
    end
  endtask

  // Apply this cycle's effects to the model, then move to the next cycle.
  task automatic advance();
    bit any;
    int w;
    int i;
    int np;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_asleep[k] = 0; m_waking[k] = 0; m_idle[k] = 0; m_last[k] = 1; m_pend[k] = -1;
      end else begin
        any = req[2*k] | req[2*k+1];
        w   = win[k];
        np  = -1;
        if (w >= 0) begin
          i = 2*k + w;
          m_last[k] = w;
          if (we[i] == 4'h0) begin
            np = w;
            m_pend_data[k] = shadow[k][adr[i]];
          end else begin
            for (int b = 0; b < 4; b++)
              if (we[i][b]) shadow[k][adr[i]][8*b +: 8] = wdata[i][8*b +: 8];
          end
        end
        if (m_waking[k]) begin
          m_waking[k] = 0;
          m_idle[k]   = 0;
        end else if (m_asleep[k]) begin
          if (any || scan_mode) begin
            m_asleep[k] = 0;
            m_waking[k] = 1;
          end
        end else begin
          if (!any && m_idle[k] == IDLE_LIMIT && !scan_mode) m_asleep[k] = 1;
          if (!any && m_pend[k] < 0) m_idle[k] = (m_idle[k] < IDLE_LIMIT) ? m_idle[k] + 1 : IDLE_LIMIT;
          else                       m_idle[k] = 0;
        end
        m_pend[k] = np;
      end
    end
    @(posedge CLK);
    #1;
    cycle++;
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  // Same command on a port of both instances.
  task automatic drive(input int p, input bit r, input logic [3:0] w,
                       input logic [10:0] a, input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      req[2*k+p]   = r;
      we[2*k+p]    = w;
      adr[2*k+p]   = a;
      wdata[2*k+p] = d;
    end
  endtask

  logic [3:0] hist_p0 [2];
  logic [3:0] hist_p1 [2];
  int         rate;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 2048; a++) shadow[k][a] = 32'h0;
      m_asleep[k] = 0; m_waking[k] = 0; m_idle[k] = 0; m_last[k] = 1; m_pend[k] = -1;
      m_pend_data[k] = 32'h0; win[k] = -1;
    end
    reset_n   = 1'b0;
    scan_mode = 1'b0;
    req = '0; we = '0; adr = '0; wdata = '0;
    @(posedge CLK);
    #1;

    // Reset held with a read pending: no grant, no access.
    drive(0, 1, 4'h0, 11'h005, 32'h0);
    step();
    step();
    reset_n = 1'b1;

    // Write then read back on port 0.
    drive(0, 1, 4'hF, 11'h005, 32'hA5A5_1234); step();
    drive(0, 1, 4'h0, 11'h005, 32'h0);         step();
    drive(0, 0, 4'h0, 11'h000, 32'h0);
    settle_check();
    chk("wr_rd_valid", 0, 32'(rvalid[0]), 32'h1);
    chk("wr_rd_data",  0, rdata[0], 32'hA5A5_1234);
    advance();

    // Contention for four cycles, right after reset.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    drive(0, 1, 4'h0, 11'h005, 32'h0);
    drive(1, 1, 4'h0, 11'h006, 32'h0);
    for (int k = 0; k < 2; k++) begin hist_p0[k] = 4'h0; hist_p1[k] = 4'h0; end
    for (int c = 0; c < 4; c++) begin
      settle_check();
      for (int k = 0; k < 2; k++) begin
        hist_p0[k] = {hist_p0[k][2:0], gnt[2*k]};
        hist_p1[k] = {hist_p1[k][2:0], gnt[2*k+1]};
      end
      advance();
    end
    chk("rr_p0_seq",  0, 32'(hist_p0[0]), 32'hA);
    chk("rr_p1_seq",  0, 32'(hist_p1[0]), 32'h5);
    chk("fix_p0_seq", 1, 32'(hist_p0[1]), 32'hF);
    chk("fix_p1_seq", 1, 32'(hist_p1[1]), 32'h0);
    drive(1, 0, 4'h0, 11'h000, 32'h0);

    // Byte write over all-ones at the top address.
    drive(0, 1, 4'hF,    11'h7FF, 32'hFFFF_FFFF); step();
    drive(0, 1, 4'b0100, 11'h7FF, 32'h00CC_0000); step();
    drive(0, 1, 4'h0,    11'h7FF, 32'h0);         step();
    drive(0, 0, 4'h0,    11'h000, 32'h0);
    settle_check();
    chk("byte_we_rd", 0, rdata[0], 32'hFFCC_FFFF);
    chk("byte_we_rd", 1, rdata[2], 32'hFFCC_FFFF);
    advance();

    // Idle into power-down, then wake on a port 1 request.
    repeat (IDLE_LIMIT + 3) step();
    drive(1, 1, 4'h0, 11'h005, 32'h0);
    settle_check();
    chk("pd_entered", 0, 32'(pd[0]), 32'h1);
    advance();
    settle_check();
    chk("wake_pd",    0, 32'(pd[0]),  32'h0);
    chk("wake_nognt", 0, 32'(gnt[1]), 32'h0);
    advance();
    settle_check();
    chk("wake_gnt",   0, 32'(gnt[1]), 32'h1);
    advance();
    drive(1, 0, 4'h0, 11'h000, 32'h0);
    step();

    // Reset in the cycle a read would be granted.
    drive(0, 1, 4'h0, 11'h7FF, 32'h0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    drive(0, 0, 4'h0, 11'h000, 32'h0);
    settle_check();
    chk("rst_no_rvalid", 0, 32'(rvalid[0]), 32'h0);
    advance();

    // Scan mode through a long idle stretch.
    scan_mode = 1'b1;
    repeat (IDLE_LIMIT + 4) step();
    settle_check();
    chk("scan_no_pd", 0, 32'(pd[0]), 32'h0);
    advance();
    scan_mode = 1'b0;

    // Random traffic; each requester holds its command until granted.
    rate = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(3))
          0:       rate = 0;
          1:       rate = 15;
          2:       rate = 60;
          default: rate = 100;
        endcase
      end
      reset_n = ($urandom_range(399) != 0);
      if ($urandom_range(99) == 0) scan_mode = ~scan_mode;
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (!(req[2*k+p] && win[k] != p)) begin
            req[2*k+p]   = ($urandom_range(99) < rate);
            we[2*k+p]    = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
            adr[2*k+p]   = 11'($urandom_range(15)) | (($urandom_range(3) == 0) ? 11'h7F0 : 11'h000);
            wdata[2*k+p] = $urandom;
          end
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
